// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester and the subtractive GCD calculator.
package gcd_pkg;

  localparam int GCD_W       = 8;
  localparam int GCD_TIMEOUT = 1023;
  localparam int GCD_TW      = 10;

  // Requester FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } gcd_state_e;

  // Calculator FSM states.
  typedef enum logic [1:0] {
    CALC_IDLE = 2'd0,
    CALC_RUN  = 2'd1,
    CALC_HOLD = 2'd2,
    CALC_CLR  = 2'd3
  } gcd_calc_state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// Bundle of the upstream operand stream, downstream result stream and the
// calculator start/done bus.
//
// Handshake rules: a transfer on a valid/ready stream happens on a rising clk
// edge where both valid and ready are 1; once valid is raised the payload is
// held constant until that transfer. On the calculator bus, start is held
// high with stable P/Q until done is seen, and done stays high until shortly
// after start drops.
interface gcd_requester_if import gcd_pkg::*; #(
  parameter int W = GCD_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_p;
  logic [W-1:0] in_q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic         out_err;
  logic         calc_start;
  logic [W-1:0] calc_p;
  logic [W-1:0] calc_q;
  logic [W-1:0] calc_r;
  logic         calc_done;

  // Requester view.
  modport master (
    input  in_valid, in_p, in_q, out_ready, calc_r, calc_done,
    output in_ready, out_valid, out_r, out_err, calc_start, calc_p, calc_q
  );

  // Environment view: operand source, result sink and calculator.
  modport slave (
    output in_valid, in_p, in_q, out_ready, calc_r, calc_done,
    input  in_ready, out_valid, out_r, out_err, calc_start, calc_p, calc_q
  );
endinterface

// File: rtl/gcd_calc.sv
// Subtractive GCD calculator. Samples P/Q when start rises, raises done with
// R when the operands meet, and clears done two cycles after start drops.
// Zero operands never converge; the requester keeps them away from here.
module gcd_calc import gcd_pkg::*; #(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         done
);

  gcd_calc_state_e state, state_n;
  logic [W-1:0]    a, a_n;
  logic [W-1:0]    b, b_n;
  logic [W-1:0]    r_n;
  logic            done_n;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CALC_IDLE;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      r     <= r_n;
      done  <= done_n;
    end
  end

  // Next-state: one subtraction per cycle until a == b.
  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    r_n     = r;
    done_n  = done;
    case (state)
      CALC_IDLE: begin
        if (start) begin
          a_n     = p;
          b_n     = q;
          state_n = CALC_RUN;
        end
      end
      CALC_RUN: begin
        if (!start) begin
          // Requester abandoned the request (reset); drop the work.
          state_n = CALC_IDLE;
        end else if (a == b) begin
          r_n     = a;
          done_n  = 1'b1;
          state_n = CALC_HOLD;
        end else if (a > b) begin
          a_n = a - b;
        end else begin
          b_n = b - a;
        end
      end
      CALC_HOLD: begin
        if (!start) state_n = CALC_CLR;
      end
      CALC_CLR: begin
        done_n  = 1'b0;
        state_n = CALC_IDLE;
      end
      default: state_n = CALC_IDLE;
    endcase
  end

endmodule

// File: rtl/gcd_requester.sv
// Initiator side of the GCD start/done handshake. Takes operand pairs from
// an upstream stream, runs them through the calculator (or answers zero
// operands locally), and returns results downstream. A timeout marks the
// calculator as hung and sets a sticky fault; afterwards every request is
// answered with an error so upstream never stalls.
module gcd_requester import gcd_pkg::*; #(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = GCD_TIMEOUT,
  parameter int TW      = GCD_TW
) (
  input  logic                   clk,
  input  logic                   rst,
  gcd_requester_if.master        bus,
  output logic                   fault,
  output gcd_state_e             state_dbg
);

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  gcd_state_e    state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic          start_q, start_n;
  logic [W-1:0]  p_q, p_n;
  logic [W-1:0]  q_q, q_n;
  logic          valid_q, valid_n;
  logic [W-1:0]  r_q, r_n;
  logic          err_q, err_n;
  logic          fault_q, fault_n;
  logic          accept;
  logic          p_zero, q_zero;

  // A done still high from the previous run must not be mistaken for the
  // next one, so new work is refused until the calculator has cleared it.
  assign bus.in_ready = (state == IDLE) && !bus.calc_done;
  assign accept       = bus.in_valid && bus.in_ready;
  assign p_zero       = (bus.in_p == '0);
  assign q_zero       = (bus.in_q == '0);

  assign bus.calc_start = start_q;
  assign bus.calc_p     = p_q;
  assign bus.calc_q     = q_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_r      = r_q;
  assign bus.out_err    = err_q;
  assign fault          = fault_q;
  assign state_dbg      = state;

  // All outputs and the timeout counter are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      r_q     <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      start_q <= start_n;
      p_q     <= p_n;
      q_q     <= q_n;
      valid_q <= valid_n;
      r_q     <= r_n;
      err_q   <= err_n;
      fault_q <= fault_n;
    end
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start_n = start_q;
    p_n     = p_q;
    q_n     = q_q;
    valid_n = valid_q;
    r_n     = r_q;
    err_n   = err_q;
    fault_n = fault_q;
    case (state)
      IDLE: begin
        if (accept) begin
          // P/Q change on the same edge start rises, so they are already
          // stable when the calculator first sees start.
          p_n = bus.in_p;
          q_n = bus.in_q;
          if (fault_q) begin
            state_n = RESP;
            valid_n = 1'b1;
            r_n     = '0;
            err_n   = 1'b1;
          end else if (p_zero || q_zero) begin
            state_n = RESP;
            valid_n = 1'b1;
            r_n     = bus.in_p | bus.in_q;
            err_n   = p_zero && q_zero;
          end else begin
            state_n = ISSUE;
            start_n = 1'b1;
            cnt_n   = '0;
          end
        end
      end
      ISSUE: begin
        cnt_n = cnt + 1'b1;
        // done takes priority over a timeout landing on the same cycle.
        if (bus.calc_done) begin
          start_n = 1'b0;
          r_n     = bus.calc_r;
          err_n   = 1'b0;
          valid_n = 1'b1;
          state_n = RESP;
        end else if (cnt == CNT_LAST) begin
          start_n = 1'b0;
          fault_n = 1'b1;
          r_n     = '0;
          err_n   = 1'b1;
          valid_n = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
- Initiator side of the GCD start/done handshake. Accepts operand pairs from an upstream valid/ready stream and drives start/P/Q into a GCD calculator.
- Waits for done, captures R, releases start, and returns the result on a downstream valid/ready stream.
- Resolves zero operands locally, since the subtractive calculator never terminates on them.
- Guards each calculation with a timeout and a sticky fault flag.

Parameters:
- W, 8, operand/result width; must match the calculator.
- TIMEOUT, 1023, maximum cycles calc_start may stay high without calc_done before a fault is declared.
- TW, 10, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_p  in  W  operand P.
- in_q  in  W  operand Q.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_r  out  W  GCD result.
- out_err  out  1  result invalid (0,0 input, timeout, or faulted).
- calc_start  out  1  start to calculator.
- calc_p  out  W  P to calculator.
- calc_q  out  W  Q to calculator.
- calc_r  in  W  calculator result; valid while calc_done=1.
- calc_done  in  1  calculator done.
- fault  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset: all state updates on clk rising edge when rst=0, regardless of current state.
  - State returns to IDLE.
  - calc_start, out_valid, out_err and fault go to 0.
  - out_r, calc_p, calc_q and the timeout counter go to 0.
  - Reset in ISSUE drops calc_start the cycle after the reset edge. No response is produced for the aborted request.
- Registers: all outputs are registered; no combinational path from inputs to outputs except in_ready.
- in_ready = (state==IDLE) & !calc_done. Never start while a stale done is still high; the calculator clears done 2 cycles after start drops.
- States: IDLE, ISSUE, RESP.
- IDLE, on accept (in_valid & in_ready), latch in_p/in_q into calc_p/calc_q, then:
  - fault=1: go to RESP with out_r=0, out_err=1; calc_start stays 0.
  - in_p==0 or in_q==0: go to RESP with out_r = in_p | in_q, out_err = (in_p==0 & in_q==0); calc_start stays 0.
  - otherwise: go to ISSUE, set calc_start=1, clear the counter. calc_p/calc_q are updated on the same edge, so they are stable before the calculator samples start.
- ISSUE:
  - calc_p/calc_q are held constant.
  - The counter increments each cycle.
  - If calc_done=1: capture out_r=calc_r, out_err=0, calc_start<=0, go to RESP.
  - Else if counter==TIMEOUT-1: calc_start<=0, fault<=1, out_r=0, out_err=1, go to RESP.
  - If both conditions hold in the same cycle, done wins.
- RESP:
  - out_valid=1; out_r and out_err are held stable while out_ready=0.
  - On out_ready=1, drop out_valid and go to IDLE.
- Latency, nonzero operands, no backpressure: out_valid rises 1 cycle after the first cycle calc_done=1 is seen. Zero or faulted path: out_valid rises 1 cycle after accept.
- Back-to-back requests: the next accept is possible one cycle after the RESP handshake, gated by calc_done low.
- After a fault the calculator is considered hung. No further starts are issued; every request is answered with out_err=1, so upstream never deadlocks.

Decomposition:
- Shared package gcd_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - default width GCD_W=8;
  - default GCD_TIMEOUT=1023.
- gcd_calc should migrate to the same GCD_W.
- No sub-module; the counter and FSM stay inline. The testbench instantiates gcd_calc as the responder.

Test Plan:
- Nominal: in (48,18) with the real calculator, out_ready=1 -> one calc_start pulse, held until done; out_r=6, out_err=0; calc_start low before out_valid.
- Zero operand: in (0,35) -> out_r=35, out_err=0, out_valid 1 cycle after accept; calc_start never asserts. Then in (0,0) -> out_r=0, out_err=1.
- Backpressure and sequencing: (255,1) then (100,75) with out_ready low for 5 cycles -> out_r=1 held stable with out_valid high; next accept only after the handshake and calc_done low; second result out_r=25.
- Timeout: TIMEOUT=16, stub responder never raises done, in (9,6) -> calc_start high exactly 16 cycles, then out_err=1, out_r=0, fault=1. Next request (4,2) -> out_err=1, no calc_start.
- Stale done: stub holds calc_done=1 for 3 cycles after start drops -> in_ready=0 throughout; accept only after calc_done=0.
- Reset mid-ISSUE: rst=0 for 1 cycle during ISSUE -> calc_start=0, out_valid=0, fault=0 next cycle; no response emitted; the next request completes normally.
